// File: rtl/account_store.sv
// rtl/account_store.sv - per-card account store with PIN check, lockout and balance commit
module account_store #(
    parameter int CARD_W    = 6,
    parameter int PASS_W    = 16,
    parameter int BAL_W     = 20,
    parameter int USERS     = 10,
    parameter int MAX_TRIES = 3,
    parameter int TRY_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CARD_W-1:0] card_number,
    input  logic              card_in,
    input  logic              card_out,
    input  logic [PASS_W-1:0] pin,
    input  logic              pin_valid,
    input  logic              commit,
    input  logic [BAL_W-1:0]  updated_balance,
    input  logic              cfg_we,
    input  logic [CARD_W-1:0] cfg_addr,
    input  logic [PASS_W-1:0] cfg_password,
    input  logic [BAL_W-1:0]  cfg_balance,
    output logic [BAL_W-1:0]  balance,
    output logic              session_active,
    output logic              auth_ok,
    output logic              auth_fail,
    output logic              card_rejected,
    output logic              lock_event,
    output logic [TRY_W-1:0]  attempts_left,
    output logic              commit_ack
);

    // Index width just wide enough for the account arrays.
    localparam int IDX_W = (USERS > 1) ? $clog2(USERS) : 1;
    localparam logic [CARD_W:0]  USERS_C = (CARD_W+1)'(USERS);
    localparam logic [TRY_W-1:0] MAX_C   = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, LOAD, AUTH, SESSION} state_t;

    state_t state, state_n;

    // Account storage; deliberately untouched by reset.
    logic [PASS_W-1:0] pass_mem [USERS];
    logic [BAL_W-1:0]  bal_mem  [USERS];

    // Lockout bookkeeping; cleared by reset.
    logic [TRY_W-1:0]  fail_cnt [USERS];
    logic [USERS-1:0]  lock;

    logic [IDX_W-1:0]  idx, idx_n;
    logic [PASS_W-1:0] pass_reg;
    logic [BAL_W-1:0]  bal_reg;

    logic [BAL_W-1:0]  balance_n;
    logic [TRY_W-1:0]  attempts_n;
    logic              session_n, auth_ok_n, auth_fail_n, rejected_n, lock_event_n, ack_n;
    logic              fail_clr, fail_inc, lock_set, mem_commit;

    logic              card_ok, cfg_ok, card_locked;
    logic [IDX_W-1:0]  card_idx, cfg_idx;
    logic [TRY_W-1:0]  fail_nx;

    assign card_idx = card_number[IDX_W-1:0];
    assign cfg_idx  = cfg_addr[IDX_W-1:0];
    assign card_ok  = ({1'b0, card_number} < USERS_C);
    assign cfg_ok   = (state == IDLE) && cfg_we && ({1'b0, cfg_addr} < USERS_C);
    // A same-cycle provisioning write to this card unlocks it before the card is judged.
    assign card_locked = lock[card_idx] && !(cfg_ok && (cfg_idx == card_idx));
    assign fail_nx  = fail_cnt[idx] + TRY_W'(1);

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        balance_n    = balance;
        session_n    = session_active;
        attempts_n   = attempts_left;
        auth_ok_n    = 1'b0;
        auth_fail_n  = 1'b0;
        rejected_n   = 1'b0;
        lock_event_n = 1'b0;
        ack_n        = 1'b0;
        fail_clr     = 1'b0;
        fail_inc     = 1'b0;
        lock_set     = 1'b0;
        mem_commit   = 1'b0;
        case (state)
            IDLE: begin
                if (card_in) begin
                    if (card_ok && !card_locked) begin
                        idx_n   = card_idx;
                        state_n = LOAD;
                    end else begin
                        rejected_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                attempts_n = MAX_C - fail_cnt[idx];
                state_n    = AUTH;
            end
            AUTH: begin
                if (pin_valid) begin
                    if (pin == pass_reg) begin
                        fail_clr   = 1'b1;
                        auth_ok_n  = 1'b1;
                        session_n  = 1'b1;
                        balance_n  = bal_reg;
                        attempts_n = MAX_C;
                        state_n    = SESSION;
                    end else begin
                        fail_inc    = 1'b1;
                        auth_fail_n = 1'b1;
                        attempts_n  = MAX_C - fail_nx;
                        if (fail_nx == MAX_C) begin
                            lock_set     = 1'b1;
                            lock_event_n = 1'b1;
                            attempts_n   = '0;
                            state_n      = IDLE;
                        end
                    end
                end
                // The PIN above is judged first; ejection still ends the attempt.
                if (card_out) begin
                    state_n   = IDLE;
                    session_n = 1'b0;
                    balance_n = '0;
                end
            end
            SESSION: begin
                if (commit) begin
                    mem_commit = 1'b1;
                    balance_n  = updated_balance;
                    ack_n      = 1'b1;
                end
                if (card_out) begin
                    state_n   = IDLE;
                    session_n = 1'b0;
                    balance_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, session context and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            pass_reg       <= '0;
            bal_reg        <= '0;
            balance        <= '0;
            session_active <= 1'b0;
            auth_ok        <= 1'b0;
            auth_fail      <= 1'b0;
            card_rejected  <= 1'b0;
            lock_event     <= 1'b0;
            attempts_left  <= '0;
            commit_ack     <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            if (state == LOAD) begin
                pass_reg <= pass_mem[idx];
                bal_reg  <= bal_mem[idx];
            end
            balance        <= balance_n;
            session_active <= session_n;
            auth_ok        <= auth_ok_n;
            auth_fail      <= auth_fail_n;
            card_rejected  <= rejected_n;
            lock_event     <= lock_event_n;
            attempts_left  <= attempts_n;
            commit_ack     <= ack_n;
        end
    end

    // Per-account failure counters and lock bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < USERS; i++) begin
                fail_cnt[i] <= '0;
            end
            lock <= '0;
        end else begin
            if (cfg_ok) begin
                fail_cnt[cfg_idx] <= '0;
                lock[cfg_idx]     <= 1'b0;
            end
            if (fail_clr) begin
                fail_cnt[idx] <= '0;
            end
            if (fail_inc) begin
                fail_cnt[idx] <= fail_nx;
            end
            if (lock_set) begin
                lock[idx] <= 1'b1;
            end
        end
    end

    // Password and balance arrays: provisioning writes and session commits.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            pass_mem[cfg_idx] <= cfg_password;
            bal_mem[cfg_idx]  <= cfg_balance;
        end
        if (mem_commit) begin
            bal_mem[idx] <= updated_balance;
        end
    end

endmodule

// File: tb/tb_account_store.sv
// tb/tb_account_store.sv - table-driven scoreboard bench for account_store
module tb_account_store;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  card_number;
    logic        card_in, card_out, pin_valid, commit, cfg_we;
    logic [15:0] pin, cfg_password;
    logic [19:0] updated_balance, cfg_balance;
    logic [5:0]  cfg_addr;
    logic [19:0] balance;
    logic        session_active, auth_ok, auth_fail, card_rejected, lock_event, commit_ack;
    logic [1:0]  attempts_left;
    logic [27:0] obs;

    account_store dut (
        .clk(clk), .rst(rst), .card_number(card_number), .card_in(card_in),
        .card_out(card_out), .pin(pin), .pin_valid(pin_valid), .commit(commit),
        .updated_balance(updated_balance), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_password(cfg_password), .cfg_balance(cfg_balance), .balance(balance),
        .session_active(session_active), .auth_ok(auth_ok), .auth_fail(auth_fail),
        .card_rejected(card_rejected), .lock_event(lock_event),
        .attempts_left(attempts_left), .commit_ack(commit_ack)
    );

    always #5 clk = ~clk;

    assign obs = {balance, session_active, auth_ok, auth_fail, card_rejected,
                  lock_event, attempts_left, commit_ack};

    typedef enum {NOP, CARD, OUT, PIN, COMMIT, CFG, CFGCARD, PINOUT, COMMITOUT, RST} op_t;
    typedef struct {
        string       name;
        op_t         op;
        logic [5:0]  card;
        logic [15:0] pw;
        logic [19:0] val;
        logic [27:0] exp;
    } vec_t;
    typedef struct {
        string       name;
        logic [27:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic logic [27:0] e(int bal, bit s, bit ok, bit fl, bit rj, bit lk, int att, bit ack);
        logic [19:0] b;
        logic [1:0]  a;
        b = bal[19:0];
        a = att[1:0];
        return {b, s, ok, fl, rj, lk, a, ack};
    endfunction

    function automatic void add(string n, op_t op, int card, int pw, int val, logic [27:0] x);
        vec_t v;
        v.name = n; v.op = op; v.card = card[5:0]; v.pw = pw[15:0]; v.val = val[19:0]; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic [27:0] got, logic [27:0] x);
        tests++;
        if (got !== x) begin
            failed++;
            $display("FAIL %s: got bal=%0d sess=%b ok=%b fail=%b rej=%b lock=%b att=%0d ack=%b, expected bal=%0d sess=%b ok=%b fail=%b rej=%b lock=%b att=%0d ack=%b",
                     n, got[27:8], got[7], got[6], got[5], got[4], got[3], got[2:1], got[0],
                     x[27:8], x[7], x[6], x[5], x[4], x[3], x[2:1], x[0]);
        end
    endtask

    task automatic zero_inputs();
        rst = 1'b1; card_number = '0; card_in = 0; card_out = 0; pin = '0; pin_valid = 0;
        commit = 0; updated_balance = '0; cfg_we = 0; cfg_addr = '0; cfg_password = '0; cfg_balance = '0;
    endtask

    task automatic apply(vec_t v);
        sb_t s;
        @(posedge clk);
        #2;
        zero_inputs();
        case (v.op)
            CARD:      begin card_in = 1; card_number = v.card; end
            OUT:       card_out = 1;
            PIN:       begin pin_valid = 1; pin = v.pw; end
            PINOUT:    begin pin_valid = 1; pin = v.pw; card_out = 1; end
            COMMIT:    begin commit = 1; updated_balance = v.val; end
            COMMITOUT: begin commit = 1; updated_balance = v.val; card_out = 1; end
            CFG:       begin cfg_we = 1; cfg_addr = v.card; cfg_password = v.pw; cfg_balance = v.val; end
            CFGCARD:   begin cfg_we = 1; cfg_addr = v.card; cfg_password = v.pw; cfg_balance = v.val;
                             card_in = 1; card_number = v.card; end
            RST: begin
                commit = 1; updated_balance = v.val; rst = 1'b0;
                #1 check("rst_async_clear", obs, '0);
            end
            default: ;
        endcase
        s.name = v.name;
        s.exp  = v.exp;
        sb.push_back(s);
    endtask

    // Monitor: each expectation is compared one cycle after its stimulus.
    initial begin
        sb_t s;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                s = sb.pop_front();
                check(s.name, obs, s.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        add("cfg3",            CFG,       3,  'h1234, 500, e(0,0,0,0,0,0,0,0));
        add("card3",           CARD,      3,  0,      0,   e(0,0,0,0,0,0,0,0));
        add("load3",           NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin_ok",          PIN,       0,  'h1234, 0,   e(500,1,1,0,0,0,3,0));
        add("session",         NOP,       0,  0,      0,   e(500,1,0,0,0,0,3,0));
        add("commit350",       COMMIT,    0,  0,      350, e(350,1,0,0,0,0,3,1));
        add("ack_once",        NOP,       0,  0,      0,   e(350,1,0,0,0,0,3,0));
        add("out",             OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("idle_pin_ignored",PIN,       0,  'h1234, 0,   e(0,0,0,0,0,0,3,0));
        add("card3b",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load3b",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin_ok_350",      PIN,       0,  'h1234, 0,   e(350,1,1,0,0,0,3,0));
        add("commit111",       COMMIT,    0,  0,      111, e(111,1,0,0,0,0,3,1));
        add("commit222",       COMMIT,    0,  0,      222, e(222,1,0,0,0,0,3,1));
        add("card_in_in_sess", CARD,      5,  0,      0,   e(222,1,0,0,0,0,3,0));
        add("outb",            OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("card3c",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load3c",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("bad1",            PIN,       0,  1,      0,   e(0,0,0,1,0,0,2,0));
        add("bad2",            PIN,       0,  2,      0,   e(0,0,0,1,0,0,1,0));
        add("bad3_lock",       PIN,       0,  3,      0,   e(0,0,0,1,0,1,0,0));
        add("locked_reject",   CARD,      3,  0,      0,   e(0,0,0,0,1,0,0,0));
        add("reject_one_cycle",NOP,       0,  0,      0,   e(0,0,0,0,0,0,0,0));
        add("cfg_and_card",    CFGCARD,   3,  'h1234, 222, e(0,0,0,0,0,0,0,0));
        add("load_unlocked",   NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin_ok_unlocked", PIN,       0,  'h1234, 0,   e(222,1,1,0,0,0,3,0));
        add("outd",            OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("card12_reject",   CARD,      12, 0,      0,   e(0,0,0,0,1,0,3,0));
        add("cfg12_dropped",   CFG,       12, 'h5555, 9,   e(0,0,0,0,0,0,3,0));
        add("card10_reject",   CARD,      10, 0,      0,   e(0,0,0,0,1,0,3,0));
        add("cfg9",            CFG,       9,  'hAAAA, 7,   e(0,0,0,0,0,0,3,0));
        add("card9",           CARD,      9,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load9",           NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin9_ok",         PIN,       0,  'hAAAA, 0,   e(7,1,1,0,0,0,3,0));
        add("out9",            OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("card3e",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load3e",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("bad_e",           PIN,       0,  5,      0,   e(0,0,0,1,0,0,2,0));
        add("out_in_auth",     OUT,       0,  0,      0,   e(0,0,0,0,0,0,2,0));
        add("card3f",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,2,0));
        add("load3f_kept",     NOP,       0,  0,      0,   e(0,0,0,0,0,0,2,0));
        add("bad_pin_and_out", PINOUT,    0,  6,      0,   e(0,0,0,1,0,0,1,0));
        add("card3g",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,1,0));
        add("load3g",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,1,0));
        add("pin_ok_g",        PIN,       0,  'h1234, 0,   e(222,1,1,0,0,0,3,0));
        add("outg",            OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("card3h",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load3h_cleared",  NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin_ok_h",        PIN,       0,  'h1234, 0,   e(222,1,1,0,0,0,3,0));
        add("commit_and_out",  COMMITOUT, 0,  0,      444, e(0,0,0,0,0,0,3,1));
        add("idle_commit_ign", COMMIT,    0,  0,      555, e(0,0,0,0,0,0,3,0));
        add("card9_l",         CARD,      9,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load9_l",         NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("bad9_1",          PIN,       0,  0,      0,   e(0,0,0,1,0,0,2,0));
        add("bad9_2",          PIN,       0,  0,      0,   e(0,0,0,1,0,0,1,0));
        add("bad9_3_lock",     PIN,       0,  0,      0,   e(0,0,0,1,0,1,0,0));
        add("card9_rejected",  CARD,      9,  0,      0,   e(0,0,0,0,1,0,0,0));
        add("card3i",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,0,0));
        add("load3i",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("pin_ok_444",      PIN,       0,  'h1234, 0,   e(444,1,1,0,0,0,3,0));
        add("rst_mid_session", RST,       0,  0,      999, e(0,0,0,0,0,0,0,0));
        add("card9_unlocked",  CARD,      9,  0,      0,   e(0,0,0,0,0,0,0,0));
        add("load9_reset_cnt", NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("out9_auth",       OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("card3r",          CARD,      3,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("load3r",          NOP,       0,  0,      0,   e(0,0,0,0,0,0,3,0));
        add("bal_kept_444",    PIN,       0,  'h1234, 0,   e(444,1,1,0,0,0,3,0));
        add("out_final",       OUT,       0,  0,      0,   e(0,0,0,0,0,0,3,0));

        zero_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", obs, '0);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        @(posedge clk);
        #2 zero_inputs();
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/account_store.md
Name: account_store

Overview:
- Parametrised per-card account store for the ATM datapath, sitting between the card reader and the transaction unit.
- Validates the card number and verifies the entered PIN internally; the stored password is never driven out of the block.
- Counts failed PIN attempts per account and locks an account that reaches the limit.
- Exposes the balance only during an authenticated session, commits updated balances with an acknowledge, and has a configuration port for provisioning accounts.

Parameters:
CARD_W, 6, card number width
PASS_W, 16, password/PIN width
BAL_W, 20, balance width
USERS, 10, number of accounts (valid card numbers 0..USERS-1; USERS <= 2^CARD_W)
MAX_TRIES, 3, consecutive wrong PINs that lock an account (>=1)
TRY_W, 2, attempt counter width (2^TRY_W > MAX_TRIES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
card_number  in  CARD_W  card presented, sampled with card_in
card_in  in  1  one-cycle pulse: card inserted
card_out  in  1  one-cycle pulse: card ejected / session end
pin  in  PASS_W  entered PIN
pin_valid  in  1  one-cycle pulse: pin valid
commit  in  1  one-cycle pulse: write updated_balance
updated_balance  in  BAL_W  new balance from transaction unit
cfg_we  in  1  provisioning write strobe
cfg_addr  in  CARD_W  account to provision
cfg_password  in  PASS_W  password to store
cfg_balance  in  BAL_W  balance to store
balance  out  BAL_W  current account balance, valid while session_active
session_active  out  1  authenticated session in progress
auth_ok  out  1  pulse: PIN accepted
auth_fail  out  1  pulse: PIN rejected
card_rejected  out  1  pulse: invalid or locked card
lock_event  out  1  pulse: account has just become locked
attempts_left  out  TRY_W  remaining tries for the current card
commit_ack  out  1  pulse: balance written

Behaviour:
- Reset (async, rst=0):
  - FSM goes to IDLE.
  - All outputs are 0.
  - All per-account fail counters and lock bits are cleared.
  - Password/balance arrays keep their contents; reset does not touch them.
  - Reset in any state aborts the session with no write-back.
- All pulse outputs are high for exactly one cycle, registered, and asserted the cycle after the causing input.
- FSM states: IDLE, LOAD, AUTH, SESSION.
- IDLE:
  - card_in with card_number < USERS and the account not locked: latch the index, go to LOAD.
  - card_in with card_number >= USERS, or the account locked: card_rejected pulses; stay in IDLE.
  - pin_valid, commit and card_out are ignored.
- LOAD (one cycle):
  - Read the password and balance into internal registers.
  - attempts_left = MAX_TRIES - fail_cnt[idx].
  - Go to AUTH.
- AUTH:
  - pin_valid with pin == stored password: fail_cnt[idx] cleared, auth_ok pulses, go to SESSION. session_active and a valid balance appear in the same cycle as auth_ok.
  - pin_valid with a mismatch: fail_cnt[idx]++, auth_fail pulses, attempts_left decrements.
  - If the count reaches MAX_TRIES: set lock[idx], pulse lock_event together with auth_fail, attempts_left = 0, go to IDLE.
  - card_out: go to IDLE. The fail count is retained, so partial failures persist across insertions until a correct PIN or a cfg write.
  - If pin_valid and card_out occur in the same cycle, the PIN is evaluated first, then the FSM goes to IDLE.
- SESSION:
  - commit: balance_mem[idx] and the balance output both take updated_balance; commit_ack pulses. Back-to-back commits are each acked.
  - card_out: go to IDLE. session_active and balance drop to 0 the next cycle.
  - commit and card_out in the same cycle: the write is performed and acked, then the FSM goes to IDLE.
  - card_in during a session is ignored.
- No arithmetic is performed on balances; updated_balance is stored verbatim at BAL_W bits.
- Configuration (cfg_we):
  - Accepted only in IDLE with cfg_addr < USERS.
  - Writes the password and balance, and clears that account's fail_cnt and lock bit.
  - Otherwise the write is silently dropped.
  - If cfg_we and card_in arrive in the same IDLE cycle, the cfg write takes effect first; card_in is then judged on post-write lock state.
- The password is never routed to any output.

Test Plan:
- Provision card 3 with password 16'h1234 and balance 500; card_in=3, pin=16'h1234 -> auth_ok pulse, session_active=1, balance=500, attempts_left=3.
- Same session: commit with updated_balance=350, then card_out; reinsert and authenticate -> balance=350; commit_ack seen exactly once per commit.
- card_in=3 with pins 1, 2, 3 (all wrong) -> auth_fail x3, attempts_left 2, 1, 0, lock_event on the third; next card_in=3 -> card_rejected; cfg write to 3 -> account unlocked.
- card_in=12 (>= USERS) -> card_rejected pulse, FSM stays IDLE, no balance output; cfg_we to addr 12 -> no effect.
- One wrong PIN, card_out, reinsert -> attempts_left=2; correct PIN -> count cleared (next session shows attempts_left=3).
- Mid-session rst low for 1 cycle with a commit pending -> all outputs 0, IDLE, balance_mem unchanged, locks cleared; commit+card_out in the same cycle -> write acked, then IDLE.
